// File: rtl/full_adder_pair.sv
// full_adder_pair: adds two WIDTH-bit operands and a carry-in in two independent
// ways and registers both results side by side, plus a flag showing whether they
// disagree.
//   - Behavioural path: a single arithmetic expression.
//   - Structural path: a ripple chain of gate-level full-adder cells.
// Ports:
//   clk      - clock; all state updates on its rising edge
//   rst      - synchronous, active-high reset; clears sf, ss and mismatch
//   x, y     - WIDTH-bit operands
//   cin      - carry-in
//   sf       - registered behavioural result; sf[WIDTH] is carry-out, sf[WIDTH-1:0] is the sum
//   ss       - registered structural result, same layout as sf
//   mismatch - registered flag, 1 when the two combinational results differ
module full_adder_pair #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH:0]   sf,
  output logic [WIDTH:0]   ss,
  output logic             mismatch
);

  localparam int unsigned RW = WIDTH + 1;

  logic [WIDTH:0] sf_c;
  wire  [WIDTH:0] carry;
  wire  [WIDTH-1:0] sum_s;
  logic [WIDTH:0] ss_c;
  logic           mismatch_c;

  // Behavioural path: operands are zero-extended first so the carry-out is kept.
  assign sf_c = RW'(x) + RW'(y) + RW'(cin);

  // Structural path: ripple chain of gate-level full adders, with cin entering cell 0.
  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    wire ab_xor;
    wire ab_and;
    wire c_and;
    xor u_x0 (ab_xor, x[i], y[i]);
    xor u_x1 (sum_s[i], ab_xor, carry[i]);
    and u_a0 (ab_and, x[i], y[i]);
    and u_a1 (c_and, carry[i], ab_xor);
    or  u_o0 (carry[i+1], ab_and, c_and);
  end

  assign ss_c = {carry[WIDTH], sum_s};

  // Logical inequality, so unknown inputs show up as an unknown flag rather than being hidden.
  assign mismatch_c = (sf_c != ss_c);

  // Output registers; reset takes priority over capturing new results.
  always_ff @(posedge clk) begin
    if (rst) begin
      sf       <= '0;
      ss       <= '0;
      mismatch <= 1'b0;
    end else begin
      sf       <= sf_c;
      ss       <= ss_c;
      mismatch <= mismatch_c;
    end
  end

endmodule

// File: tb/tb_full_adder_pair.sv
module tb_full_adder_pair;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // WIDTH=1 instance
  logic [0:0] x1, y1;
  logic       c1;
  logic [1:0] sf1, ss1;
  logic       mm1;

  // WIDTH=4 instance
  logic [3:0] x4, y4;
  logic       c4;
  logic [4:0] sf4, ss4;
  logic       mm4;

  // WIDTH=8 instance
  logic [7:0] x8, y8;
  logic       c8;
  logic [8:0] sf8, ss8;
  logic       mm8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  full_adder_pair #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .cin(c1),
    .sf(sf1), .ss(ss1), .mismatch(mm1)
  );

  full_adder_pair #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .x(x4), .y(y4), .cin(c4),
    .sf(sf4), .ss(ss4), .mismatch(mm4)
  );

  full_adder_pair #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .x(x8), .y(y8), .cin(c8),
    .sf(sf8), .ss(ss8), .mismatch(mm8)
  );

  // Advance past one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check all three outputs of one instance against the reference sum.
  task automatic chk3(input string tag, input logic [31:0] f, input logic [31:0] s,
                      input logic m, input int unsigned expv);
    chk({tag, ".sf"}, f, 32'(expv));
    chk({tag, ".ss"}, s, 32'(expv));
    chk({tag, ".mismatch"}, 32'(m), 32'd0);
  endtask

  initial begin
    int unsigned expv;
    int unsigned exp4;
    x1 = '0; y1 = '0; c1 = 1'b0;
    x4 = '0; y4 = '0; c4 = 1'b0;
    x8 = '0; y8 = '0; c8 = 1'b0;

    // Reset clears every instance.
    rst = 1'b1;
    tick();
    tick();
    chk3("reset_w1", 32'(sf1), 32'(ss1), mm1, 0);
    chk3("reset_w4", 32'(sf4), 32'(ss4), mm4, 0);
    chk3("reset_w8", 32'(sf8), 32'(ss8), mm8, 0);

    // First edge after release captures the current inputs.
    x1 = 1'b1; y1 = 1'b0; c1 = 1'b1;
    rst = 1'b0;
    tick();
    chk3("post_release", 32'(sf1), 32'(ss1), mm1, 2);

    // Exhaustive WIDTH=1, index bits are {x, y, cin}, each vector held two cycles.
    for (int v = 0; v < 8; v++) begin
      x1 = 1'(v >> 2);
      y1 = 1'(v >> 1);
      c1 = 1'(v);
      expv = int'(unsigned'(x1)) + int'(unsigned'(y1)) + int'(unsigned'(c1));
      tick();
      chk3($sformatf("exh_%0d_a", v), 32'(sf1), 32'(ss1), mm1, expv);
      tick();
      chk3($sformatf("exh_%0d_b", v), 32'(sf1), 32'(ss1), mm1, expv);
    end

    // Latency: an input change is not visible until the next edge.
    x1 = 1'b0; y1 = 1'b0; c1 = 1'b0;
    tick();
    chk3("lat_base", 32'(sf1), 32'(ss1), mm1, 0);
    x1 = 1'b1;
    #1;
    chk("lat_hold.sf", 32'(sf1), 32'd0);
    chk("lat_hold.ss", 32'(ss1), 32'd0);
    tick();
    chk3("lat_after", 32'(sf1), 32'(ss1), mm1, 1);

    // Mid-stream reset with all-ones inputs, then release.
    x1 = 1'b1; y1 = 1'b1; c1 = 1'b1;
    tick();
    chk3("max_w1", 32'(sf1), 32'(ss1), mm1, 3);
    rst = 1'b1;
    tick();
    chk3("rst_mid", 32'(sf1), 32'(ss1), mm1, 0);
    rst = 1'b0;
    #1;
    chk("rst_hold.sf", 32'(sf1), 32'd0);
    tick();
    chk3("rst_release", 32'(sf1), 32'(ss1), mm1, 3);

    // Wrap-around at WIDTH=4.
    x4 = 4'd15; y4 = 4'd1; c4 = 1'b0;
    tick();
    chk3("wrap4_a", 32'(sf4), 32'(ss4), mm4, 16);
    x4 = 4'd15; y4 = 4'd15; c4 = 1'b1;
    tick();
    chk3("wrap4_b", 32'(sf4), 32'(ss4), mm4, 31);

    // Random vectors on WIDTH=8 (and WIDTH=4 alongside), one new vector per cycle.
    for (int n = 0; n < 1200; n++) begin
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      c8 = 1'($urandom);
      x4 = 4'($urandom);
      y4 = 4'($urandom);
      c4 = 1'($urandom);
      expv = int'(unsigned'(x8)) + int'(unsigned'(y8)) + int'(unsigned'(c8));
      exp4 = int'(unsigned'(x4)) + int'(unsigned'(y4)) + int'(unsigned'(c4));
      tick();
      chk3("rand8", 32'(sf8), 32'(ss8), mm8, expv);
      chk3("rand4", 32'(sf4), 32'(ss4), mm4, exp4);
    end

    // Fixed corners on WIDTH=8.
    x8 = 8'hFF; y8 = 8'hFF; c8 = 1'b1;
    tick();
    chk3("max_w8", 32'(sf8), 32'(ss8), mm8, 511);
    x8 = 8'h00; y8 = 8'h00; c8 = 1'b0;
    tick();
    chk3("zero_w8", 32'(sf8), 32'(ss8), mm8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_adder_pair.md
FULL_ADDER_PAIR -- requirements
Module: full_adder_pair

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the operand width in bits (legal range 1..32).
Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port x, input, WIDTH bits: operand A.
REQ-005 The block SHALL have port y, input, WIDTH bits: operand B.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-007 The block SHALL have port sf, output, WIDTH+1 bits: registered result of the behavioural (function) path; sf[WIDTH] is carry-out and sf[WIDTH-1:0] is the sum.
REQ-008 The block SHALL have port ss, output, WIDTH+1 bits: registered result of the structural path, with the same layout as sf.
REQ-009 The block SHALL have port mismatch, output, 1 bit: registered flag, high when the two paths disagree.

Function
REQ-010 Function path: the block SHALL compute {cout, sum} = x + y + cin as a single behavioural arithmetic expression, zero-extended to WIDTH+1 bits.
REQ-011 Structural path: the block SHALL build a ripple chain of WIDTH one-bit full-adder cells using gate primitives only.
  - Each cell: s = a XOR b XOR c; co = (a AND b) OR (c AND (a XOR b)).
  - No arithmetic operators in this path.
REQ-012 Cell 0 of the structural chain SHALL take cin as its carry-in.
REQ-013 The carry-out of cell i SHALL feed the carry-in of cell i+1.
REQ-014 The carry-out of the last cell SHALL drive ss[WIDTH].
REQ-015 Both results SHALL be captured in registers on the rising clk edge, giving a latency of exactly 1 cycle from an input change to its result on sf and ss.
REQ-016 mismatch SHALL be registered in the same cycle as sf and ss, set to 1 exactly when the combinational function and structural results differ.
REQ-017 For all legal inputs the two paths SHALL produce identical results, so mismatch remains 0.
REQ-018 The block SHALL have no handshake; new inputs are accepted every cycle.
REQ-019 Wrap-around: at maximum operands the full WIDTH+1-bit result SHALL be produced without truncation; for WIDTH=1 the result of x=1, y=1, cin=1 is 2'b11.
REQ-020 Unknown (X) inputs SHALL propagate without masking.

Reset
REQ-021 While rst=1 at a rising clk edge, sf, ss and mismatch SHALL all be set to 0 on that edge.
REQ-022 Reset SHALL take priority over capture of new inputs.
REQ-023 In the first edge after rst deasserts, the block SHALL capture the current inputs normally.
REQ-024 Reset asserted mid-stream SHALL discard the pending result; the output holds 0 until one edge after release.
REQ-025 Outputs are undefined before the first reset edge, and the bench SHALL apply reset first.

Verification
REQ-026 Exhaustive check, WIDTH=1: apply all 8 combinations of {x, y, cin}, each held for at least 2 cycles.
  - Results: 000->00, 010->01, 100->01, 110->10, 001->01, 011->10, 101->10, 111->11.
  - sf and ss match each time; mismatch=0.
REQ-027 Latency check: change x from 0 to 1 (y=0, cin=0) at cycle n -> sf and ss read 00 through cycle n, then 01 after edge n+1.
REQ-028 Reset check: assert rst while x=y=cin=1 -> sf=ss=00 and mismatch=0 on the next edge; release rst -> 11 one edge later.
REQ-029 Wrap-around check, WIDTH=4: x=15, y=1, cin=0 -> sf=ss=5'b10000.
  - Then x=15, y=15, cin=1 -> 5'b11111.
REQ-030 Random check, WIDTH=8: at least 1000 random vectors -> sf equals the reference x+y+cin each cycle, ss equals sf, and mismatch stays 0 throughout.
